uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- Memory-mapped UART transmitter sitting directly downstream of the SoC address decoder, alongside the other bus slaves.
- Uses the common slave handshake: valid/instr/addr/wdata/wstrb in, rdata/ready out. The address arriving here is already offset-relative.
- Buffers software-written bytes in a FIFO and serialises them as 8N1 frames on one output pin.
- Exposes status and a programmable baud divisor.

Parameters:
- CLK_DIV, 868: reset value of the baud divisor, in clock cycles per bit.
- FIFO_DEPTH, 8: TX FIFO entries. Must be a power of two, at least 2.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- uart_valid  in  1  request strobe, one cycle per request.
- uart_instr  in  1  instruction-fetch flag. Ignored; treated as a data access.
- uart_addr  in  32  byte offset within the device.
- uart_wdata  in  32  write data.
- uart_wstrb  in  4  byte write strobes. 0 means read.
- uart_rdata  out  32  read data, valid only while ready=1.
- uart_ready  out  1  request-complete pulse.
- uart_txd  out  1  serial output, idle high.

Behaviour:
- Reset values:
  - uart_ready=0, uart_rdata=0, uart_txd=1.
  - FIFO empty; FSM in IDLE; div=CLK_DIV; overflow=0.
  - Reset mid-frame aborts the frame immediately: txd=1 on the next cycle and FIFO contents are discarded.
- Register map, decoded on uart_addr[3:2]; uart_addr[1:0] is ignored:
  - 0x0 TXDATA (W): if wstrb[0]=1, push wdata[7:0]. Reads return 0.
  - 0x4 STATUS (R):
    - bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky).
    - bits[15:8] FIFO count; all other bits 0.
    - Any write with wstrb!=0 clears overflow.
  - 0x8 DIV (RW): byte lanes written per wstrb. Reads return the current div.
  - 0xC: reserved. Reads return 0; writes are ignored.
- Handshake:
  - A request sampled at edge T gives uart_ready=1 for exactly one cycle after T (cycle T+1). uart_rdata holds the read value during that cycle and is 0 otherwise.
  - Back-to-back valids on consecutive cycles are each acknowledged one cycle later.
  - Register effects (push, DIV update, overflow clear) are visible from cycle T+1.
- FIFO:
  - Circular buffer with wrap-around read/write pointers and an explicit count of width clog2(FIFO_DEPTH)+1.
  - A push while full drops the byte and sets overflow; the request is still acknowledged.
  - A push and a pop in the same cycle while full: the pop frees a slot, so the push succeeds and no overflow is raised.
  - A push and a pop in the same cycle while empty is not possible, because the pop requires non-empty at the edge.
- TX FSM states: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: txd=1. If the FIFO is non-empty: pop into a shift register, latch div into bit_div (a value of 0 is treated as 1), load the bit counter with bit_div-1, and go to START.
  - START: txd=0 for bit_div cycles.
  - DATA: txd=shift[0] for bit_div cycles per bit, LSB first. Shift right after each bit; after 8 bits go to STOP.
  - STOP: txd=1 for bit_div cycles, then IDLE.
  - IDLE with a non-empty FIFO pops on the same edge it evaluates, so back-to-back frames have no extra idle cycle.
  - The frame period is exactly 10*bit_div cycles.
  - A DIV write mid-frame affects only the next frame.
- Timing: a TXDATA write sampled at edge T with the FSM idle and the FIFO empty gives:
  - FIFO non-empty at T+1;
  - pop at edge T+1;
  - txd=0 from cycle T+2.
- uart_txd is driven from a flop; it has no combinational path from the bus.

Test Plan:
- Reset then read STATUS -> ready one cycle after valid, rdata=0x00000002 (empty), txd=1.
- Write DIV=4, then TXDATA=0x55 -> txd low 2 cycles after the TXDATA edge, then:
  - 4 cycles 0;
  - bits 1,0,1,0,1,0,1,0 at 4 cycles each;
  - 4 cycles 1;
  - 40 cycles total per frame, then STATUS=0x00000002.
- With DIV=4, write 9 bytes 0x00..0x08 on consecutive cycles:
  - the 1st is popped immediately and 8 fill the FIFO;
  - a 10th write sets overflow;
  - STATUS bit3=1 and bit0=1, count=8;
  - a write to STATUS clears bit3.
  - All 9 stored frames appear back-to-back with no idle gap, in order 0x00..0x08.
- Write DIV=0, then TXDATA=0xA3 -> 1 cycle per bit; txd sequence 0,1,1,0,0,0,1,0,1,1.
- Assert reset mid-DATA of a frame with 3 bytes queued -> txd=1 the next cycle; STATUS after reset =0x00000002; DIV reads CLK_DIV.
- Read 0xC and write 0xC=0xFFFFFFFF -> ready pulses, rdata=0, DIV and FIFO unchanged.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: memory-mapped 8N1 UART transmitter with a TX FIFO.
//
// Software pushes bytes through TXDATA. They are queued in a FIFO and sent LSB
// first, at a programmable number of clock cycles per bit.
//
// Ports:
//   clock       in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   uart_valid  in   request strobe, one cycle per request
//   uart_instr  in   fetch flag; every access is treated as a data access
//   uart_addr   in   byte offset; bits [3:2] select the register
//   uart_wdata  in   write data
//   uart_wstrb  in   byte write strobes; all zero means a read
//   uart_rdata  out  read data; non-zero only while uart_ready is high
//   uart_ready  out  one-cycle acknowledge, one cycle after the request
//   uart_txd    out  serial line (idle high), driven from a flop
//
// Register map (uart_addr[3:2]):
//   0 TXDATA  W   wstrb[0] pushes wdata[7:0]; reads return 0
//   1 STATUS  R   {count[15:8], overflow[3], busy[2], empty[1], full[0]};
//                 any write clears overflow
//   2 DIV     RW  cycles per bit, byte-lane writable; 0 is treated as 1
//   3 -       reserved; reads return 0, writes are ignored
//
// state  | meaning
// IDLE   | line high, waiting for a queued byte
// START  | start bit (low) for bit_div cycles
// DATA   | 8 data bits, LSB first, bit_div cycles each
// STOP   | stop bit (high) for bit_div cycles; chains straight into the next frame
module uart_tx #(
    parameter int CLK_DIV    = 868,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        uart_valid,
    input  logic        uart_instr,
    input  logic [31:0] uart_addr,
    input  logic [31:0] uart_wdata,
    input  logic [3:0]  uart_wstrb,
    output logic [31:0] uart_rdata,
    output logic        uart_ready,
    output logic        uart_txd
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

    state_t        r_state, w_state_nxt;
    logic [7:0]    r_fifo [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic [31:0]   r_div;
    logic [31:0]   r_bit_div, w_bit_div_nxt;
    logic [31:0]   r_bit_cnt, w_bit_cnt_nxt;
    logic [2:0]    r_bit_idx, w_bit_idx_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
    logic          r_txd, w_txd_nxt;
    logic          r_ready;
    logic [31:0]   r_rdata;

    logic [1:0]    w_sel;
    logic          w_wr, w_rd, w_full, w_empty, w_busy;
    logic          w_stop_done, w_pop, w_push_req, w_push;
    logic [31:0]   w_status, w_rd_val, w_load_div;
    logic          w_unused;

    assign w_unused = ^{uart_instr, uart_addr[31:4], uart_addr[1:0]};

    assign w_sel       = uart_addr[3:2];
    assign w_wr        = uart_valid && (uart_wstrb != 4'd0);
    assign w_rd        = uart_valid && (uart_wstrb == 4'd0);
    assign w_full      = (r_count == CW'(FIFO_DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_busy      = (r_state != ST_IDLE);
    assign w_stop_done = (r_state == ST_STOP) && (r_bit_cnt == '0);
    // The last stop cycle may pop directly so consecutive frames have no idle gap.
    assign w_pop       = !w_empty && ((r_state == ST_IDLE) || w_stop_done);
    assign w_push_req  = w_wr && (w_sel == 2'd0) && uart_wstrb[0];
    // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
    assign w_push      = w_push_req && (!w_full || w_pop);
    assign w_load_div  = (r_div == '0) ? 32'd1 : r_div;
    assign w_status    = {16'd0, 8'(r_count), 4'd0, r_ovf, w_busy, w_empty, w_full};

    always_comb begin
        w_rd_val = '0;
        case (w_sel)
            2'd1:    w_rd_val = w_status;
            2'd2:    w_rd_val = r_div;
            default: w_rd_val = '0;
        endcase
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_bit_div_nxt = r_bit_div;
        w_txd_nxt     = 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (w_pop) begin
                    w_state_nxt   = ST_START;
                    w_shift_nxt   = r_fifo[r_rd_ptr];
                    w_bit_div_nxt = w_load_div;
                    w_bit_cnt_nxt = w_load_div - 32'd1;
                    w_txd_nxt     = 1'b0;
                end
            end
            ST_START: begin
                w_txd_nxt = 1'b0;
                if (r_bit_cnt == '0) begin
                    w_state_nxt   = ST_DATA;
                    w_bit_cnt_nxt = r_bit_div - 32'd1;
                    w_bit_idx_nxt = 3'd0;
                    w_txd_nxt     = r_shift[0];
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt - 32'd1;
                end
            end
            ST_DATA: begin
                w_txd_nxt = r_shift[0];
                if (r_bit_cnt == '0) begin
                    w_bit_cnt_nxt = r_bit_div - 32'd1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = ST_STOP;
                        w_txd_nxt   = 1'b1;
                    end else begin
                        w_shift_nxt   = {1'b0, r_shift[7:1]};
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                        w_txd_nxt     = r_shift[1];
                    end
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt - 32'd1;
                end
            end
            ST_STOP: begin
                if (r_bit_cnt == '0) begin
                    if (w_pop) begin
                        w_state_nxt   = ST_START;
                        w_shift_nxt   = r_fifo[r_rd_ptr];
                        w_bit_div_nxt = w_load_div;
                        w_bit_cnt_nxt = w_load_div - 32'd1;
                        w_txd_nxt     = 1'b0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt - 32'd1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_ovf     <= 1'b0;
            r_div     <= 32'(CLK_DIV);
            r_bit_div <= 32'd1;
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_txd     <= 1'b1;
            r_ready   <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_div <= w_bit_div_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_txd     <= w_txd_nxt;
            r_ready   <= uart_valid;
            r_rdata   <= w_rd ? w_rd_val : 32'd0;

            if (w_push) begin
                r_fifo[r_wr_ptr] <= uart_wdata[7:0];
                r_wr_ptr         <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            if (w_push_req && !w_push) begin
                r_ovf <= 1'b1;
            end else if (w_wr && (w_sel == 2'd1)) begin
                r_ovf <= 1'b0;
            end

            if (w_wr && (w_sel == 2'd2)) begin
                for (int i = 0; i < 4; i++) begin
                    if (uart_wstrb[i]) begin
                        r_div[8*i +: 8] <= uart_wdata[8*i +: 8];
                    end
                end
            end
        end
    end

    assign uart_txd   = r_txd;
    assign uart_ready = r_ready;
    assign uart_rdata = r_rdata;

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: a queue/timeline model of the transmitter checked every
// cycle, an independent line receiver, and directed literal expectations.
module tb_uart_tx;

    localparam int DEPTH = 8;
    localparam int CDIV  = 868;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        uart_valid = 1'b0;
    logic        uart_instr = 1'b0;
    logic [31:0] uart_addr  = '0;
    logic [31:0] uart_wdata = '0;
    logic [3:0]  uart_wstrb = '0;
    logic [31:0] uart_rdata;
    logic        uart_ready;
    logic        uart_txd;

    always #5 clock = ~clock;

    uart_tx #(.CLK_DIV(CDIV), .FIFO_DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .uart_valid (uart_valid),
        .uart_instr (uart_instr),
        .uart_addr  (uart_addr),
        .uart_wdata (uart_wdata),
        .uart_wstrb (uart_wstrb),
        .uart_rdata (uart_rdata),
        .uart_ready (uart_ready),
        .uart_txd   (uart_txd)
    );

    int vecs = 0;
    int errs = 0;

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The line is a timeline: a frame is a byte plus its position in a
    // 10*bd-cycle window; bytes wait in a plain queue.
    logic [7:0]  m_q[$];
    logic [31:0] m_div = 32'(CDIV);
    logic        m_ovf = 1'b0;
    logic        m_act = 1'b0;
    int          m_pos = 0;
    int          m_bd  = 1;
    logic [7:0]  m_byte = '0;
    logic        m_ready = 1'b0;
    logic [31:0] m_rdata = '0;

    function automatic logic m_txd();
        int k;
        if (!m_act) return 1'b1;
        k = m_pos / m_bd;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return m_byte[k-1];
    endfunction

    // Advance the model across the next rising edge using the inputs that edge samples.
    task automatic m_step();
        int          cnt;
        logic        pop;
        logic [31:0] stat, rv;
        if (reset) begin
            m_q.delete();
            m_div = 32'(CDIV); m_ovf = 1'b0; m_act = 1'b0; m_pos = 0; m_bd = 1;
            m_ready = 1'b0; m_rdata = '0;
            return;
        end
        cnt  = m_q.size();
        pop  = (cnt != 0) && (!m_act || (m_pos == 10*m_bd - 1));
        stat = '0;
        stat[0]    = (cnt == DEPTH);
        stat[1]    = (cnt == 0);
        stat[2]    = m_act;
        stat[3]    = m_ovf;
        stat[15:8] = cnt[7:0];
        case (uart_addr[3:2])
            2'd1:    rv = stat;
            2'd2:    rv = m_div;
            default: rv = '0;
        endcase
        if (m_act) begin
            m_pos++;
            if (m_pos == 10*m_bd) m_act = 1'b0;
        end
        if (pop) begin
            m_byte = m_q.pop_front();
            m_bd   = (m_div == 0) ? 1 : int'(m_div);
            m_pos  = 0;
            m_act  = 1'b1;
        end
        m_ready = uart_valid;
        m_rdata = '0;
        if (uart_valid) begin
            if (uart_wstrb == 4'd0) begin
                m_rdata = rv;
            end else begin
                case (uart_addr[3:2])
                    2'd0: if (uart_wstrb[0]) begin
                        if (cnt < DEPTH || pop) m_q.push_back(uart_wdata[7:0]);
                        else m_ovf = 1'b1;
                    end
                    2'd1: m_ovf = 1'b0;
                    2'd2: for (int i = 0; i < 4; i++)
                        if (uart_wstrb[i]) m_div[8*i +: 8] = uart_wdata[8*i +: 8];
                    default: ;
                endcase
            end
        end
    endtask

    bit armed = 0;
    always @(negedge clock) begin
        if (armed) begin
            chk1("cyc_ready", uart_ready, m_ready);
            chk32("cyc_rdata", uart_rdata, m_rdata);
            chk1("cyc_txd", uart_txd, m_txd());
        end
        m_step();
        armed = 1;
    end

    // ---------------- independent line receiver ----------------
    int         mon_bd = 4;
    int         cyc = 0;
    int         rx_t0 = 0;
    int         off;
    bit         rx_busy = 0;
    logic [7:0] rx_sh = '0;
    logic [7:0] rx_bytes[$];
    int         rx_starts[$];

    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            rx_busy = 0;
        end else if (!rx_busy) begin
            if (uart_txd === 1'b0) begin
                rx_busy = 1; rx_t0 = cyc; rx_starts.push_back(cyc);
            end
        end else begin
            off = cyc - rx_t0;
            for (int k = 0; k < 8; k++)
                if (off == mon_bd*(k+1) + mon_bd/2) rx_sh[k] = uart_txd;
            if (off == 10*mon_bd - 1) begin
                rx_bytes.push_back(rx_sh);
                rx_busy = 0;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic bus_req(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd);
        @(posedge clock); #1;
        uart_valid = 1'b1; uart_addr = a; uart_wdata = d; uart_wstrb = s;
        @(posedge clock); #1;
        uart_valid = 1'b0; uart_wstrb = '0;
        chk1("bus_ready", uart_ready, 1'b1);
        rd = uart_rdata;
    endtask

    task automatic wr_burst(input int n, input logic [7:0] first, input logic [7:0] step);
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
            uart_valid = 1'b1; uart_addr = 32'h0; uart_wstrb = 4'h1;
            uart_wdata = {24'd0, 8'(first + 8'(i) * step)};
        end
        @(posedge clock); #1;
        uart_valid = 1'b0; uart_wstrb = '0;
    endtask

    logic cap [0:63];

    task automatic capture(input int n);
        cap[0] = uart_txd;
        for (int k = 1; k < n; k++) begin
            @(posedge clock); #1;
            cap[k] = uart_txd;
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic [9:0]  slots;

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // Reset state
        bus_req(32'h4, 32'h0, 4'h0, rd);
        chk32("rst_status", rd, 32'h0000_0002);
        chk1("rst_txd", uart_txd, 1'b1);

        // DIV=4, one frame of 0x55
        bus_req(32'h8, 32'h4, 4'hF, rd);
        bus_req(32'h8, 32'h0, 4'h0, rd);
        chk32("div_rd4", rd, 32'h4);
        mon_bd = 4;
        bus_req(32'h0, 32'h55, 4'h1, rd);
        capture(43);
        chk1("f55_pre", cap[0], 1'b1);
        slots = 10'b1010101010;
        for (int s = 0; s < 10; s++)
            for (int j = 0; j < 4; j++)
                chk1($sformatf("f55_s%0d_c%0d", s, j), cap[1 + 4*s + j], slots[s]);
        chk1("f55_post", cap[41], 1'b1);
        bus_req(32'h4, 32'h0, 4'h0, rd);
        chk32("f55_status", rd, 32'h0000_0002);

        // Fill, overflow, clear, back-to-back drain
        rx_bytes.delete();
        rx_starts.delete();
        wr_burst(10, 8'h00, 8'h01);
        bus_req(32'h4, 32'h0, 4'h0, rd);
        chk32("ovf_status", rd, 32'h0000_080D);
        bus_req(32'h4, 32'h0, 4'hF, rd);
        bus_req(32'h4, 32'h0, 4'h0, rd);
        chk32("ovf_cleared", rd, 32'h0000_0805);
        repeat (380) @(posedge clock);
        chk32("rx_count", 32'(rx_bytes.size()), 32'd9);
        for (int i = 0; i < rx_bytes.size() && i < 9; i++)
            chk32($sformatf("rx_byte%0d", i), {24'd0, rx_bytes[i]}, 32'(i));
        for (int i = 1; i < rx_starts.size() && i < 9; i++)
            chk32($sformatf("rx_gap%0d", i), 32'(rx_starts[i] - rx_starts[i-1]), 32'd40);
        bus_req(32'h4, 32'h0, 4'h0, rd);
        chk32("drain_status", rd, 32'h0000_0002);

        // DIV=0 treated as 1, frame 0xA3
        bus_req(32'h8, 32'h0, 4'hF, rd);
        mon_bd = 1;
        bus_req(32'h0, 32'hA3, 4'h1, rd);
        capture(13);
        chk1("fa3_pre", cap[0], 1'b1);
        slots = 10'b1101000110;
        for (int s = 0; s < 10; s++)
            chk1($sformatf("fa3_b%0d", s), cap[1 + s], slots[s]);
        chk1("fa3_post", cap[11], 1'b1);

        // Reserved offset
        bus_req(32'hC, 32'h0, 4'h0, rd);
        chk32("rsv_read", rd, 32'h0);
        bus_req(32'hC, 32'hFFFF_FFFF, 4'hF, rd);
        chk32("rsv_wr_rdata", rd, 32'h0);
        bus_req(32'h8, 32'h0, 4'h0, rd);
        chk32("rsv_div", rd, 32'h0);
        bus_req(32'h4, 32'h0, 4'h0, rd);
        chk32("rsv_status", rd, 32'h0000_0002);

        // Reset in the middle of a data bit with 3 bytes queued
        bus_req(32'h8, 32'h4, 4'hF, rd);
        mon_bd = 4;
        wr_burst(4, 8'h00, 8'h11);
        repeat (4) @(posedge clock);
        #1;
        chk1("mid_txd_low", uart_txd, 1'b0);
        reset = 1'b1;
        @(posedge clock); #1;
        chk1("rst_mid_txd", uart_txd, 1'b1);
        reset = 1'b0;
        bus_req(32'h4, 32'h0, 4'h0, rd);
        chk32("rst_mid_status", rd, 32'h0000_0002);
        bus_req(32'h8, 32'h0, 4'h0, rd);
        chk32("rst_mid_div", rd, 32'(CDIV));
        repeat (60) @(posedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
